// File: rtl/l2_in_arbiter_pkg.sv
// Shared constants and types for the L2 input arbiter: request-buffer op codes,
// issue source encoding, arbiter states and payload widths.
package l2_in_arbiter_pkg;

    localparam int L2_N_REQS = 4;
    localparam int L2_CPU_W  = 64;
    localparam int L2_FWD_W  = 40;
    localparam int L2_RSP_W  = 168;

    localparam logic [2:0] L2_REQS_IDLE       = 3'd0;
    localparam logic [2:0] L2_REQS_LOOKUP     = 3'd1;
    localparam logic [2:0] L2_REQS_PEEK_REQ   = 3'd2;
    localparam logic [2:0] L2_REQS_PEEK_FLUSH = 3'd3;
    localparam logic [2:0] L2_REQS_PEEK_FWD   = 3'd4;

    typedef enum logic [1:0] {
        SRC_RSP   = 2'd0,
        SRC_FWD   = 2'd1,
        SRC_CPU   = 2'd2,
        SRC_FLUSH = 2'd3
    } issue_src_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } arb_state_t;

    typedef logic [L2_CPU_W-1:0] cpu_payload_t;
    typedef logic [L2_FWD_W-1:0] fwd_payload_t;
    typedef logic [L2_RSP_W-1:0] rsp_payload_t;

    // Request-buffer op code presented during the ISSUE cycle of a grant.
    function automatic logic [2:0] op_for_src(input issue_src_t src);
        logic [2:0] op;
        case (src)
            SRC_RSP:   op = L2_REQS_LOOKUP;
            SRC_FWD:   op = L2_REQS_PEEK_FWD;
            SRC_CPU:   op = L2_REQS_PEEK_REQ;
            SRC_FLUSH: op = L2_REQS_PEEK_FLUSH;
            default:   op = L2_REQS_IDLE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/l2_in_arbiter_skid.sv
// One-entry valid/ready holding buffer; accepts when empty and empties only
// when the downstream consume strobe retires the held item.
module l2_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         consume,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // Load on transfer, clear on consume; the two never coincide since ready = !valid.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_valid && !valid_q) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (consume) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Buffer state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign in_ready  = !valid_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/l2_in_arbiter.sv
// Input stage ahead of the L2 request buffer: buffers rsp/fwd/cpu items, arbitrates
// them with flush, peeks the request buffer and tracks free entries.
module l2_in_arbiter
    import l2_in_arbiter_pkg::*;
#(
    parameter int N_REQS = L2_N_REQS,
    parameter int CPU_W  = L2_CPU_W,
    parameter int FWD_W  = L2_FWD_W,
    parameter int RSP_W  = L2_RSP_W,
    parameter int CNT_W  = $clog2(N_REQS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_valid,
    output logic             cpu_ready,
    input  logic [CPU_W-1:0] cpu_data,
    input  logic             fwd_valid,
    output logic             fwd_ready,
    input  logic [FWD_W-1:0] fwd_data,
    input  logic             rsp_valid,
    output logic             rsp_ready,
    input  logic [RSP_W-1:0] rsp_data,
    input  logic             flush_req,
    input  logic             set_set_conflict_reqs,
    input  logic             clr_set_conflict_reqs,
    input  logic             set_fwd_stall,
    input  logic             clr_fwd_stall,
    input  logic             reqs_alloc,
    input  logic             reqs_retire,
    input  logic             proc_done,
    output logic [2:0]       reqs_op_code,
    output logic             issue_valid,
    output logic [1:0]       issue_src,
    output logic [CPU_W-1:0] issue_cpu,
    output logic [FWD_W-1:0] issue_fwd,
    output logic [RSP_W-1:0] issue_rsp,
    output logic             set_conflict,
    output logic             fwd_stall,
    output logic [CNT_W-1:0] reqs_cnt
);

    arb_state_t       state_q, state_d;
    issue_src_t       grant_q, grant_d, sel_src;
    logic [2:0]       op_code_q, op_code_d;
    logic             issue_valid_q, issue_valid_d;
    logic             set_conflict_q, set_conflict_d;
    logic             fwd_stall_q, fwd_stall_d;
    logic [CNT_W-1:0] reqs_cnt_q, reqs_cnt_d;
    logic             rsp_bv, fwd_bv, cpu_bv, any_elig, done_s, have_entry;

    assign done_s     = (state_q == ST_BUSY) && proc_done;
    assign have_entry = (reqs_cnt_q != {CNT_W{1'b0}});

    l2_skid_buf #(.W(RSP_W)) u_rsp_buf (
        .clk(clk), .rst(rst), .in_valid(rsp_valid), .in_ready(rsp_ready), .in_data(rsp_data),
        .consume(done_s && (grant_q == SRC_RSP)), .out_valid(rsp_bv), .out_data(issue_rsp)
    );
    l2_skid_buf #(.W(FWD_W)) u_fwd_buf (
        .clk(clk), .rst(rst), .in_valid(fwd_valid), .in_ready(fwd_ready), .in_data(fwd_data),
        .consume(done_s && (grant_q == SRC_FWD)), .out_valid(fwd_bv), .out_data(issue_fwd)
    );
    l2_skid_buf #(.W(CPU_W)) u_cpu_buf (
        .clk(clk), .rst(rst), .in_valid(cpu_valid), .in_ready(cpu_ready), .in_data(cpu_data),
        .consume(done_s && (grant_q == SRC_CPU)), .out_valid(cpu_bv), .out_data(issue_cpu)
    );

    // Fixed-priority pick among eligible sources: rsp > fwd > cpu > flush.
    always_comb begin
        sel_src  = SRC_RSP;
        any_elig = 1'b1;
        if (rsp_bv) begin
            sel_src = SRC_RSP;
        end else if (fwd_bv && !fwd_stall_q) begin
            sel_src = SRC_FWD;
        end else if (cpu_bv && !set_conflict_q && have_entry) begin
            sel_src = SRC_CPU;
        end else if (flush_req && have_entry && !cpu_bv) begin
            sel_src = SRC_FLUSH;
        end else begin
            any_elig = 1'b0;
        end
    end

    // Grant FSM: IDLE picks, ISSUE peeks the buffer for one cycle, BUSY waits for proc_done.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        op_code_d     = L2_REQS_IDLE;
        issue_valid_d = issue_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (any_elig) begin
                    grant_d   = sel_src;
                    op_code_d = op_for_src(sel_src);
                    state_d   = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if ((grant_q == SRC_FWD) && set_fwd_stall) begin
                    state_d = ST_IDLE;
                end else if ((grant_q == SRC_CPU) && set_set_conflict_reqs) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d       = ST_BUSY;
                    issue_valid_d = 1'b1;
                end
            end
            ST_BUSY: begin
                if (proc_done) begin
                    state_d       = ST_IDLE;
                    issue_valid_d = 1'b0;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                issue_valid_d = 1'b0;
            end
        endcase
    end

    // Stall flags: set only by a rejected peek, which overrides a same-cycle clear.
    always_comb begin
        fwd_stall_d    = fwd_stall_q;
        set_conflict_d = set_conflict_q;
        if ((state_q == ST_ISSUE) && (grant_q == SRC_FWD) && set_fwd_stall) begin
            fwd_stall_d = 1'b1;
        end else if (reqs_retire || clr_fwd_stall) begin
            fwd_stall_d = 1'b0;
        end else begin
            fwd_stall_d = fwd_stall_q;
        end
        if ((state_q == ST_ISSUE) && (grant_q == SRC_CPU) && set_set_conflict_reqs) begin
            set_conflict_d = 1'b1;
        end else if (reqs_retire || clr_set_conflict_reqs) begin
            set_conflict_d = 1'b0;
        end else begin
            set_conflict_d = set_conflict_q;
        end
    end

    // Free-entry count; out-of-range updates saturate rather than wrap.
    always_comb begin
        reqs_cnt_d = reqs_cnt_q;
        if (reqs_alloc && !reqs_retire) begin
            if (have_entry) begin
                reqs_cnt_d = reqs_cnt_q - CNT_W'(1);
            end else begin
                reqs_cnt_d = reqs_cnt_q;
            end
        end else if (reqs_retire && !reqs_alloc) begin
            if (reqs_cnt_q != CNT_W'(N_REQS)) begin
                reqs_cnt_d = reqs_cnt_q + CNT_W'(1);
            end else begin
                reqs_cnt_d = reqs_cnt_q;
            end
        end else begin
            reqs_cnt_d = reqs_cnt_q;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            grant_q        <= SRC_RSP;
            op_code_q      <= L2_REQS_IDLE;
            issue_valid_q  <= 1'b0;
            set_conflict_q <= 1'b0;
            fwd_stall_q    <= 1'b0;
            reqs_cnt_q     <= CNT_W'(N_REQS);
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            op_code_q      <= op_code_d;
            issue_valid_q  <= issue_valid_d;
            set_conflict_q <= set_conflict_d;
            fwd_stall_q    <= fwd_stall_d;
            reqs_cnt_q     <= reqs_cnt_d;
        end
    end

    assign reqs_op_code = op_code_q;
    assign issue_valid  = issue_valid_q;
    assign issue_src    = grant_q;
    assign set_conflict = set_conflict_q;
    assign fwd_stall    = fwd_stall_q;
    assign reqs_cnt     = reqs_cnt_q;

endmodule

// File: tb/tb_l2_in_arbiter.sv
// Self-checking bench for l2_in_arbiter: directed corner sequences, a counter
// vector table and a randomized run against a queue-based reference model.
module tb_l2_in_arbiter;
    import l2_in_arbiter_pkg::*;

    localparam int N_REQS = 4;
    localparam int CPU_W  = 64;
    localparam int FWD_W  = 40;
    localparam int RSP_W  = 168;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cpu_valid = 1'b0, fwd_valid = 1'b0, rsp_valid = 1'b0, flush_req = 1'b0;
    logic [CPU_W-1:0] cpu_data = '0;
    logic [FWD_W-1:0] fwd_data = '0;
    logic [RSP_W-1:0] rsp_data = '0;
    logic set_set_conflict_reqs = 1'b0, clr_set_conflict_reqs = 1'b0;
    logic set_fwd_stall = 1'b0, clr_fwd_stall = 1'b0;
    logic reqs_alloc = 1'b0, reqs_retire = 1'b0, proc_done = 1'b0;
    logic cpu_ready, fwd_ready, rsp_ready, issue_valid, set_conflict, fwd_stall;
    logic [2:0] reqs_op_code;
    logic [1:0] issue_src;
    logic [CPU_W-1:0] issue_cpu;
    logic [FWD_W-1:0] issue_fwd;
    logic [RSP_W-1:0] issue_rsp;
    logic [2:0] reqs_cnt;

    int n_chk = 0;
    int n_fail = 0;

    l2_in_arbiter #(.N_REQS(N_REQS), .CPU_W(CPU_W), .FWD_W(FWD_W), .RSP_W(RSP_W)) dut (
        .clk(clk), .rst(rst),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_data(cpu_data),
        .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_data(fwd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .flush_req(flush_req),
        .set_set_conflict_reqs(set_set_conflict_reqs), .clr_set_conflict_reqs(clr_set_conflict_reqs),
        .set_fwd_stall(set_fwd_stall), .clr_fwd_stall(clr_fwd_stall),
        .reqs_alloc(reqs_alloc), .reqs_retire(reqs_retire), .proc_done(proc_done),
        .reqs_op_code(reqs_op_code), .issue_valid(issue_valid), .issue_src(issue_src),
        .issue_cpu(issue_cpu), .issue_fwd(issue_fwd), .issue_rsp(issue_rsp),
        .set_conflict(set_conflict), .fwd_stall(fwd_stall), .reqs_cnt(reqs_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic alloc;
        logic retire;
        int   exp_cnt;
    } cnt_vec_t;

    logic [CPU_W-1:0] cpu_q[$];
    logic [FWD_W-1:0] fwd_q[$];
    logic [RSP_W-1:0] rsp_q[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [191:0] rnd192();
        logic [191:0] t;
        for (int i = 0; i < 6; i++) t[i*32 +: 32] = $urandom;
        return t;
    endfunction

    // Wait (bounded) for the next peek and check its op code.
    task automatic wait_op(input logic [2:0] exp, input string name);
        int k = 0;
        while (reqs_op_code == 3'd0 && k < 30) begin
            tick();
            k++;
        end
        chk(name, {253'd0, reqs_op_code}, {253'd0, exp});
    endtask

    // From the ISSUE cycle: expect BUSY with the given source/payload, then retire it.
    task automatic serve(input logic [1:0] src, input logic [255:0] pay, input string name);
        logic [255:0] act;
        tick();
        chk({name, "_iv"}, {255'd0, issue_valid}, 256'd1);
        chk({name, "_src"}, {254'd0, issue_src}, {254'd0, src});
        chk({name, "_op_idle"}, {253'd0, reqs_op_code}, 256'd0);
        case (src)
            2'd0:    act = {88'd0, issue_rsp};
            2'd1:    act = {216'd0, issue_fwd};
            default: act = {192'd0, issue_cpu};
        endcase
        if (src != 2'd3) chk({name, "_pay"}, act, pay);
        proc_done = 1'b1;
        tick();
        proc_done = 1'b0;
        chk({name, "_done"}, {255'd0, issue_valid}, 256'd0);
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_cpu_rdy"}, {255'd0, cpu_ready}, 256'd1);
        chk({name, "_fwd_rdy"}, {255'd0, fwd_ready}, 256'd1);
        chk({name, "_rsp_rdy"}, {255'd0, rsp_ready}, 256'd1);
        chk({name, "_iv"}, {255'd0, issue_valid}, 256'd0);
        chk({name, "_op"}, {253'd0, reqs_op_code}, 256'd0);
        chk({name, "_flags"}, {254'd0, set_conflict, fwd_stall}, 256'd0);
        chk({name, "_cnt"}, {253'd0, reqs_cnt}, 256'd4);
    endtask

    initial begin
        cnt_vec_t tbl[6];
        logic [191:0] r;
        logic [CPU_W-1:0] c0;
        logic [FWD_W-1:0] f0;
        logic [RSP_W-1:0] p0;
        int m_cnt;
        int n_issued;

        tbl[0] = '{1'b0, 1'b1, 2};
        tbl[1] = '{1'b0, 1'b1, 3};
        tbl[2] = '{1'b1, 1'b1, 3};
        tbl[3] = '{1'b1, 1'b0, 2};
        tbl[4] = '{1'b0, 1'b1, 3};
        tbl[5] = '{1'b0, 1'b1, 4};

        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("reset");

        // Basic cpu grant with minimum latency.
        r = rnd192(); c0 = r[CPU_W-1:0];
        cpu_valid = 1'b1; cpu_data = c0;
        tick();
        cpu_valid = 1'b0;
        chk("s1_cpu_rdy_low", {255'd0, cpu_ready}, 256'd0);
        chk("s1_op_t1", {253'd0, reqs_op_code}, 256'd0);
        tick();
        chk("s1_op_t2", {253'd0, reqs_op_code}, 256'd2);
        serve(2'd2, {192'd0, c0}, "s1");
        chk("s1_cpu_rdy_back", {255'd0, cpu_ready}, 256'd1);

        // Three sources at once: rsp, fwd, cpu in priority order.
        r = rnd192(); p0 = r[RSP_W-1:0];
        r = rnd192(); f0 = r[FWD_W-1:0];
        r = rnd192(); c0 = r[CPU_W-1:0];
        rsp_valid = 1'b1; rsp_data = p0; fwd_valid = 1'b1; fwd_data = f0; cpu_valid = 1'b1; cpu_data = c0;
        tick();
        rsp_valid = 1'b0; fwd_valid = 1'b0; cpu_valid = 1'b0;
        wait_op(3'd1, "s2_op_rsp");
        serve(2'd0, {88'd0, p0}, "s2_rsp");
        wait_op(3'd4, "s2_op_fwd");
        serve(2'd1, {216'd0, f0}, "s2_fwd");
        wait_op(3'd2, "s2_op_cpu");
        serve(2'd2, {192'd0, c0}, "s2_cpu");

        // Set conflict on cpu peek, released by retire.
        reqs_alloc = 1'b1; tick(); reqs_alloc = 1'b0;
        r = rnd192(); c0 = r[CPU_W-1:0];
        cpu_valid = 1'b1; cpu_data = c0; tick(); cpu_valid = 1'b0;
        wait_op(3'd2, "s3_op_peek");
        set_set_conflict_reqs = 1'b1; tick(); set_set_conflict_reqs = 1'b0;
        chk("s3_conflict", {255'd0, set_conflict}, 256'd1);
        chk("s3_no_issue", {255'd0, issue_valid}, 256'd0);
        chk("s3_cpu_held", {255'd0, cpu_ready}, 256'd0);
        tick(); tick();
        chk("s3_no_repeek", {253'd0, reqs_op_code}, 256'd0);
        reqs_retire = 1'b1; tick(); reqs_retire = 1'b0;
        chk("s3_conflict_clr", {255'd0, set_conflict}, 256'd0);
        wait_op(3'd2, "s3_op_repeek");
        serve(2'd2, {192'd0, c0}, "s3");

        // Forward stall while a response arrives.
        r = rnd192(); f0 = r[FWD_W-1:0];
        r = rnd192(); p0 = r[RSP_W-1:0];
        fwd_valid = 1'b1; fwd_data = f0; tick(); fwd_valid = 1'b0;
        wait_op(3'd4, "s4_op_fwd");
        set_fwd_stall = 1'b1; rsp_valid = 1'b1; rsp_data = p0;
        tick();
        set_fwd_stall = 1'b0; rsp_valid = 1'b0;
        chk("s4_stall", {255'd0, fwd_stall}, 256'd1);
        chk("s4_fwd_held", {255'd0, fwd_ready}, 256'd0);
        wait_op(3'd1, "s4_op_rsp");
        serve(2'd0, {88'd0, p0}, "s4_rsp");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s4_fwd_blocked", {253'd0, reqs_op_code}, 256'd0);
        end
        reqs_alloc = 1'b1; tick(); reqs_alloc = 1'b0;
        reqs_retire = 1'b1; tick(); reqs_retire = 1'b0;
        chk("s4_stall_clr", {255'd0, fwd_stall}, 256'd0);
        wait_op(3'd4, "s4_op_repeek");
        serve(2'd1, {216'd0, f0}, "s4_fwd");

        // Exhausted entries: cpu and flush blocked, rsp still served.
        for (int i = 0; i < 4; i++) begin
            reqs_alloc = 1'b1; tick();
        end
        reqs_alloc = 1'b0;
        chk("s5_cnt0", {253'd0, reqs_cnt}, 256'd0);
        r = rnd192(); c0 = r[CPU_W-1:0];
        r = rnd192(); p0 = r[RSP_W-1:0];
        cpu_valid = 1'b1; cpu_data = c0; rsp_valid = 1'b1; rsp_data = p0; flush_req = 1'b1;
        tick();
        cpu_valid = 1'b0; rsp_valid = 1'b0;
        wait_op(3'd1, "s5_op_rsp");
        serve(2'd0, {88'd0, p0}, "s5_rsp");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s5_cpu_blocked", {253'd0, reqs_op_code}, 256'd0);
        end
        reqs_alloc = 1'b1; reqs_retire = 1'b1; tick(); reqs_alloc = 1'b0; reqs_retire = 1'b0;
        chk("s5_cnt_both", {253'd0, reqs_cnt}, 256'd0);
        reqs_retire = 1'b1; tick(); reqs_retire = 1'b0;
        chk("s5_cnt1", {253'd0, reqs_cnt}, 256'd1);
        wait_op(3'd2, "s5_op_cpu");
        serve(2'd2, {192'd0, c0}, "s5_cpu");
        wait_op(3'd3, "s5_op_flush");
        flush_req = 1'b0;
        serve(2'd3, 256'd0, "s5_flush");

        // Counter vector table, starting from one free entry.
        foreach (tbl[i]) begin
            reqs_alloc = tbl[i].alloc; reqs_retire = tbl[i].retire;
            tick();
            reqs_alloc = 1'b0; reqs_retire = 1'b0;
            chk($sformatf("tbl_cnt_%0d", i), {253'd0, reqs_cnt}, 256'(tbl[i].exp_cnt));
        end

        // Asynchronous reset in the middle of BUSY.
        reqs_alloc = 1'b1; tick(); reqs_alloc = 1'b0;
        r = rnd192(); c0 = r[CPU_W-1:0];
        cpu_valid = 1'b1; cpu_data = c0; tick(); cpu_valid = 1'b0;
        wait_op(3'd2, "s6_op");
        tick();
        chk("s6_busy", {255'd0, issue_valid}, 256'd1);
        rst = 1'b0;
        #1;
        chk_reset("s6_async");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Randomized traffic against a transaction-level model.
        m_cnt = N_REQS;
        n_issued = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            chk("rnd_cnt", {253'd0, reqs_cnt}, 256'(m_cnt));
            chk("rnd_cpu_rdy", {255'd0, cpu_ready}, {255'd0, cpu_q.size() == 0});
            chk("rnd_fwd_rdy", {255'd0, fwd_ready}, {255'd0, fwd_q.size() == 0});
            chk("rnd_rsp_rdy", {255'd0, rsp_ready}, {255'd0, rsp_q.size() == 0});
            proc_done = issue_valid && ($urandom_range(0, 3) == 0);
            if (issue_valid) begin
                case (issue_src)
                    2'd0: begin
                        chk("rnd_rsp_pending", {255'd0, rsp_q.size() != 0}, 256'd1);
                        if (rsp_q.size() != 0) begin
                            chk("rnd_rsp_pay", {88'd0, issue_rsp}, {88'd0, rsp_q[0]});
                            if (proc_done) void'(rsp_q.pop_front());
                        end
                    end
                    2'd1: begin
                        chk("rnd_fwd_pending", {255'd0, fwd_q.size() != 0}, 256'd1);
                        if (fwd_q.size() != 0) begin
                            chk("rnd_fwd_pay", {216'd0, issue_fwd}, {216'd0, fwd_q[0]});
                            if (proc_done) void'(fwd_q.pop_front());
                        end
                    end
                    2'd2: begin
                        chk("rnd_cpu_pending", {255'd0, cpu_q.size() != 0}, 256'd1);
                        if (cpu_q.size() != 0) begin
                            chk("rnd_cpu_pay", {192'd0, issue_cpu}, {192'd0, cpu_q[0]});
                            if (proc_done) void'(cpu_q.pop_front());
                        end
                    end
                    default: ;
                endcase
                if (proc_done) n_issued++;
            end
            r = rnd192(); cpu_data = r[CPU_W-1:0];
            r = rnd192(); fwd_data = r[FWD_W-1:0];
            r = rnd192(); rsp_data = r[RSP_W-1:0];
            cpu_valid = ($urandom_range(0, 3) == 0);
            fwd_valid = ($urandom_range(0, 3) == 0);
            rsp_valid = ($urandom_range(0, 3) == 0);
            if (cpu_valid && cpu_ready) cpu_q.push_back(cpu_data);
            if (fwd_valid && fwd_ready) fwd_q.push_back(fwd_data);
            if (rsp_valid && rsp_ready) rsp_q.push_back(rsp_data);
            flush_req = ($urandom_range(0, 7) == 0);
            set_set_conflict_reqs = ($urandom_range(0, 3) == 0);
            set_fwd_stall = ($urandom_range(0, 3) == 0);
            clr_set_conflict_reqs = ($urandom_range(0, 7) == 0);
            clr_fwd_stall = ($urandom_range(0, 7) == 0);
            reqs_alloc = (m_cnt > 0) && ($urandom_range(0, 5) == 0);
            reqs_retire = (m_cnt < N_REQS) && ($urandom_range(0, 5) == 0);
            if (reqs_alloc && !reqs_retire) m_cnt--;
            if (reqs_retire && !reqs_alloc) m_cnt++;
            tick();
        end
        cpu_valid = 1'b0; fwd_valid = 1'b0; rsp_valid = 1'b0; flush_req = 1'b0;
        set_set_conflict_reqs = 1'b0; set_fwd_stall = 1'b0;
        clr_set_conflict_reqs = 1'b0; clr_fwd_stall = 1'b0;
        reqs_alloc = 1'b0; reqs_retire = 1'b0; proc_done = 1'b0;
        chk("rnd_progress", {255'd0, n_issued > 20}, 256'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
